// File: rtl/datapath_ctrl.sv
// Multi-cycle control FSM for a 16-bit load/store core: holds IR and PSR and
// sequences fetch/decode/exec/mem/wb strobes for the datapath.
module datapath_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    input  logic [4:0]  alu_flags,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_en,
    output logic        pc_en,
    output logic        pc_sel,
    output logic [7:0]  alu_opcode,
    output logic [3:0]  rdest,
    output logic [3:0]  rsrc,
    output logic [7:0]  imm,
    output logic        b_sel,
    output logic        rf_we,
    output logic        wb_sel,
    output logic [4:0]  psr,
    output logic [2:0]  state
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [3:0] OP_RR    = 4'h0;
    localparam logic [3:0] OP_MEM   = 4'h4;
    localparam logic [3:0] OP_ADDI  = 4'h5;
    localparam logic [3:0] OP_SHIFT = 4'h8;
    localparam logic [3:0] OP_SUBI  = 4'h9;
    localparam logic [3:0] OP_CMPI  = 4'hB;
    localparam logic [3:0] OP_BCOND = 4'hC;
    localparam logic [3:0] OP_NOP   = 4'hE;

    localparam logic [3:0] EXT_LOAD = 4'h0;
    localparam logic [3:0] EXT_STOR = 4'h4;
    localparam logic [3:0] EXT_LSH  = 4'h4;
    localparam logic [3:0] EXT_ASH  = 4'h6;
    localparam logic [3:0] EXT_ADD  = 4'h5;
    localparam logic [3:0] EXT_SUB  = 4'h9;
    localparam logic [3:0] EXT_CMP  = 4'hB;

    logic [2:0]  state_q, state_d;
    logic [15:0] ir_q;
    logic [4:0]  psr_q;

    logic [3:0] op, ext, cond;
    logic       is_alu, is_load, is_stor, is_bcond;
    logic       writes_rf, sets_psr, br_taken;

    logic mem_req_c, mem_we_c, addr_sel_c, ir_en_c, pc_en_c, pc_sel_c;
    logic rf_we_c, wb_sel_c, psr_en;

    assign op   = ir_q[15:12];
    assign ext  = ir_q[7:4];
    assign cond = ir_q[11:8];

    assign is_load  = (op == OP_MEM) && (ext == EXT_LOAD);
    assign is_stor  = (op == OP_MEM) && (ext == EXT_STOR);
    assign is_bcond = (op == OP_BCOND);
    assign is_alu   = !((op == OP_MEM) || (op == OP_BCOND) || (op == OP_NOP));

    // Compares only set flags; every other ALU-class op writes back.
    assign writes_rf = !(((op == OP_RR) && (ext == EXT_CMP)) || (op == OP_CMPI));
    assign sets_psr  = ((op == OP_RR) && ((ext == EXT_ADD) || (ext == EXT_SUB) || (ext == EXT_CMP)))
                     || (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_CMPI);

    // psr bit order {C,L,F,Z,N}: Z is bit 1, C is bit 4.
    always_comb begin
        br_taken = 1'b0;
        case (cond)
            4'h0:    br_taken = psr_q[1];
            4'h1:    br_taken = !psr_q[1];
            4'h2:    br_taken = psr_q[4];
            4'h3:    br_taken = !psr_q[4];
            4'hE:    br_taken = 1'b1;
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = (is_load || is_stor) ? S_MEM : S_FETCH;
            S_MEM:    if (mem_ready) state_d = is_stor ? S_FETCH : S_WB;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req_c  = 1'b0;
        mem_we_c   = 1'b0;
        addr_sel_c = 1'b0;
        ir_en_c    = 1'b0;
        pc_en_c    = 1'b0;
        pc_sel_c   = 1'b0;
        rf_we_c    = 1'b0;
        wb_sel_c   = 1'b0;
        psr_en     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                ir_en_c   = mem_ready;
            end
            S_EXEC: begin
                if (!(is_load || is_stor)) begin
                    pc_en_c = 1'b1;
                    if (is_bcond) begin
                        pc_sel_c = br_taken;
                    end else if (is_alu) begin
                        rf_we_c = writes_rf;
                        psr_en  = sets_psr;
                    end
                end
            end
            S_MEM: begin
                mem_req_c  = 1'b1;
                addr_sel_c = 1'b1;
                mem_we_c   = is_stor;
                pc_en_c    = is_stor && mem_ready;
            end
            S_WB: begin
                rf_we_c  = 1'b1;
                wb_sel_c = 1'b1;
                pc_en_c  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q <= 16'h0000;
        end else if (ir_en_c) begin
            ir_q <= mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psr_q <= 5'b0;
        end else if (psr_en) begin
            psr_q <= alu_flags;
        end
    end

    // Strobes are forced low combinationally so a request dies the moment reset rises.
    assign mem_req  = mem_req_c  & ~reset;
    assign mem_we   = mem_we_c   & ~reset;
    assign addr_sel = addr_sel_c & ~reset;
    assign ir_en    = ir_en_c    & ~reset;
    assign pc_en    = pc_en_c    & ~reset;
    assign pc_sel   = pc_sel_c   & ~reset;
    assign rf_we    = rf_we_c    & ~reset;
    assign wb_sel   = wb_sel_c   & ~reset;

    assign alu_opcode = {ir_q[15:12], ir_q[7:4]};
    assign rdest      = ir_q[11:8];
    assign rsrc       = ir_q[3:0];
    assign imm        = ir_q[7:0];
    assign b_sel      = !((op == OP_RR) || (op == OP_MEM) ||
                          ((op == OP_SHIFT) && ((ext == EXT_LSH) || (ext == EXT_ASH))));
    assign psr        = psr_q;
    assign state      = state_q;

endmodule
